cpu_run_monitor: RTL and testbench

//   Synthesizable run controller/monitor for the multicycle CPU test environment; replaces fixed-delay $stop benches.

---
 rtl/cpu_run_monitor.sv | 147 ++++++++++++++
 tb/tb_cpu_run_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// Run controller/monitor for the multicycle CPU bench: counts cycles and retired
// instructions, stops on the halt opcode or the cycle watchdog, and keeps a PC history ring.
module cpu_run_monitor #(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MAX_CYCLES  = 475,
    parameter int unsigned HIST_DEPTH  = 8,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          PCWre,
    input  logic [PC_W-1:0]               pc,
    input  logic [31:0]                   instruction,
    output logic                          run,
    output logic                          halted,
    output logic                          timeout,
    output logic [CNT_W-1:0]              cycle_cnt,
    output logic [CNT_W-1:0]              instr_cnt,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [PC_W-1:0]               hist_pc,
    output logic                          hist_valid
);

    localparam int unsigned IDX_W  = $clog2(HIST_DEPTH);
    localparam int unsigned FILL_W = IDX_W + 1;

    localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(HIST_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_e;

    state_e            state_q;
    state_e            state_nx;
    logic              clr_c;
    logic              tick_c;
    logic              retire_c;
    logic              is_halt_c;
    logic [IDX_W-1:0]  wr_ptr;
    logic [FILL_W-1:0] fill;
    logic [IDX_W-1:0]  rd_ptr_c;
    logic [PC_W-1:0]   hist_mem [HIST_DEPTH];

    // Only the opcode field of the instruction word matters here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction[25:0];

    assign is_halt_c = (instruction[31:26] == HALT_OPCODE);

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nx = state_q;
        clr_c    = 1'b0;
        tick_c   = 1'b0;
        retire_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                    clr_c    = 1'b1;
                end
            end
            S_RUN: begin
                tick_c   = 1'b1;
                retire_c = PCWre;
                // A halt retiring on the watchdog's last cycle still reports as a halt.
                if (PCWre && is_halt_c) begin
                    state_nx = S_HALTED;
                end else if (cycle_cnt == WD_LAST) begin
                    state_nx = S_TIMEOUT;
                end
            end
            S_HALTED, S_TIMEOUT: begin
                if (start) begin
                    state_nx = S_RUN;
                    clr_c    = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            run     <= 1'b0;
            halted  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_nx;
            run     <= (state_nx == S_RUN);
            halted  <= (state_nx == S_HALTED);
            timeout <= (state_nx == S_TIMEOUT);
        end
    end

    // Cycle/instruction counters and history bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
        end else if (clr_c) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
        end else begin
            if (tick_c) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (retire_c) begin
                if (instr_cnt != CNT_SAT) begin
                    instr_cnt <= instr_cnt + CNT_W'(1);
                end
                wr_ptr <= wr_ptr + IDX_W'(1);
                if (fill != FILL_FULL) begin
                    fill <= fill + FILL_W'(1);
                end
            end
        end
    end

    // History storage needs no reset; fill gates what is visible.
    always_ff @(posedge clk) begin
        if (retire_c) begin
            hist_mem[wr_ptr] <= pc;
        end
    end

    // Index 0 is the most recent write; pointer arithmetic wraps naturally.
    assign rd_ptr_c   = wr_ptr - IDX_W'(1) - hist_idx;
    assign hist_pc    = hist_mem[rd_ptr_c];
    assign hist_valid = ({1'b0, hist_idx} < fill);

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: two parameterisations share stimulus and are checked
// every cycle against a queue-based model, plus hand-computed literal expectations.
module tb_cpu_run_monitor;

    localparam logic [31:0] LW_WORD   = 32'h8C010000;
    localparam logic [31:0] HALT_WORD = 32'hFC000000;
    localparam int ST_IDLE    = 0;
    localparam int ST_RUN     = 1;
    localparam int ST_HALTED  = 2;
    localparam int ST_TIMEOUT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pcwre = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instruction = '0;
    logic [2:0]  hist_idx = '0;
    logic [2:0]  sweep = '0;

    logic        run0, halted0, timeout0, hv0;
    logic [15:0] cyc0, ins0;
    logic [31:0] hpc0;
    logic        run1, halted1, timeout1, hv1;
    logic [15:0] cyc1, ins1;
    logic [31:0] hpc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_monitor #(.MAX_CYCLES(20), .HIST_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .PCWre(pcwre), .pc(pc),
        .instruction(instruction), .run(run0), .halted(halted0), .timeout(timeout0),
        .cycle_cnt(cyc0), .instr_cnt(ins0), .hist_idx(hist_idx[1:0]),
        .hist_pc(hpc0), .hist_valid(hv0)
    );

    cpu_run_monitor #(.MAX_CYCLES(10), .HIST_DEPTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .PCWre(pcwre), .pc(pc),
        .instruction(instruction), .run(run1), .halted(halted1), .timeout(timeout1),
        .cycle_cnt(cyc1), .instr_cnt(ins1), .hist_idx(hist_idx),
        .hist_pc(hpc1), .hist_valid(hv1)
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Model: run state, counters, and history as a newest-first queue per instance.
    int          m_st  [2];
    int          m_cyc [2];
    int          m_ins [2];
    logic [31:0] hq0[$];
    logic [31:0] hq1[$];

    function automatic int maxc(input int d);
        return (d == 0) ? 20 : 10;
    endfunction

    function automatic int depth(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int msize(input int d);
        return (d == 0) ? hq0.size() : hq1.size();
    endfunction

    function automatic logic [31:0] mhist(input int d, input int idx);
        return (d == 0) ? hq0[idx] : hq1[idx];
    endfunction

    task automatic model_clear(input int d);
        m_cyc[d] = 0;
        m_ins[d] = 0;
        if (d == 0) hq0.delete();
        else        hq1.delete();
    endtask

    task automatic model_push(input int d, input logic [31:0] v);
        if (d == 0) begin
            hq0.push_front(v);
            if (hq0.size() > depth(0)) hq0.delete(hq0.size() - 1);
        end else begin
            hq1.push_front(v);
            if (hq1.size() > depth(1)) hq1.delete(hq1.size() - 1);
        end
    endtask

    task automatic model_step(input int d);
        if (m_st[d] == ST_RUN) begin
            m_cyc[d]++;
            if (pcwre) begin
                if (m_ins[d] < 65535) m_ins[d]++;
                model_push(d, pc);
            end
            if (pcwre && instruction[31:26] == 6'h3F) m_st[d] = ST_HALTED;
            else if (m_cyc[d] == maxc(d))            m_st[d] = ST_TIMEOUT;
        end else if (start) begin
            m_st[d] = ST_RUN;
            model_clear(d);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    m_st[d] = ST_IDLE;
                    model_clear(d);
                end
            end else begin
                for (int d = 0; d < 2; d++) model_step(d);
            end
        end
    end

    task automatic compare_dut(input int d, input logic r, input logic h, input logic t,
                               input logic [15:0] c, input logic [15:0] i,
                               input logic hv, input logic [31:0] hp);
        int  idx;
        logic exp_v;
        idx   = (d == 0) ? int'(hist_idx[1:0]) : int'(hist_idx);
        exp_v = (idx < msize(d));
        chk("run", d, 32'(r), 32'(m_st[d] == ST_RUN));
        chk("halted", d, 32'(h), 32'(m_st[d] == ST_HALTED));
        chk("timeout", d, 32'(t), 32'(m_st[d] == ST_TIMEOUT));
        chk("cycle_cnt", d, 32'(c), 32'(m_cyc[d]));
        chk("instr_cnt", d, 32'(i), 32'(m_ins[d]));
        chk("hist_valid", d, 32'(hv), 32'(exp_v));
        if (exp_v) chk("hist_pc", d, hp, mhist(d, idx));
    endtask

    // Every-cycle comparison, well away from the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            compare_dut(0, run0, halted0, timeout0, cyc0, ins0, hv0, hpc0);
            compare_dut(1, run1, halted1, timeout1, cyc1, ins1, hv1, hpc1);
        end
    end

    task automatic cyc(input logic s, input logic w, input logic [31:0] p, input logic [31:0] ins);
        @(negedge clk);
        start       = s;
        pcwre       = w;
        pc          = p;
        instruction = ins;
        hist_idx    = sweep;
        sweep       = sweep + 3'd1;
    endtask

    task automatic settle(input logic [2:0] idx);
        @(negedge clk);
        start    = 1'b0;
        pcwre    = 1'b0;
        hist_idx = idx;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_run", 0, 32'(run0), 32'd0);
        chk("rst_cycle", 0, 32'(cyc0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        settle(3'd0);
        chk("idle_flags", 0, 32'({run0, halted0, timeout0}), 32'd0);
        chk("idle_valid", 0, 32'(hv0), 32'd0);

        // Halt at pc=8 with a retire every fifth cycle
        cyc(1'b1, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            repeat (4) cyc(1'b0, 1'b0, 32'h0, 32'h0);
            cyc(1'b0, 1'b1, 32'(4 * k), (k == 2) ? HALT_WORD : LW_WORD);
        end
        settle(3'd0);
        chk("t1_halted", 0, 32'(halted0), 32'd1);
        chk("t1_instr", 0, 32'(ins0), 32'd3);
        chk("t1_cycle", 0, 32'(cyc0), 32'd15);
        chk("t1_idx0", 0, hpc0, 32'd8);
        chk("t1_wd_timeout", 1, 32'(timeout1), 32'd1);
        chk("t1_wd_cycle", 1, 32'(cyc1), 32'd10);
        chk("t1_wd_instr", 1, 32'(ins1), 32'd2);
        settle(3'd1);
        chk("t1_idx1", 0, hpc0, 32'd4);
        settle(3'd2);
        chk("t1_idx2", 0, hpc0, 32'd0);
        settle(3'd3);
        chk("t1_idx3_valid", 0, 32'(hv0), 32'd0);

        // Watchdog, then frozen state with PCWre ignored
        cyc(1'b1, 1'b0, 32'h0, 32'h0);
        repeat (20) cyc(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) cyc(1'b0, 1'b1, 32'h100, LW_WORD);
        settle(3'd0);
        chk("t2_timeout", 0, 32'(timeout0), 32'd1);
        chk("t2_run", 0, 32'(run0), 32'd0);
        chk("t2_cycle", 0, 32'(cyc0), 32'd20);
        chk("t2_instr", 0, 32'(ins0), 32'd0);
        chk("t2_cycle_b", 1, 32'(cyc1), 32'd10);

        // History wrap: ten retires into a 4-entry and an 8-entry ring
        cyc(1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 32'(4 * i), LW_WORD);
        for (int i = 0; i < 8; i++) begin
            settle(3'(i));
            chk("t3_valid", 0, 32'(hv0), 32'd1);
            chk("t3_pc", 0, hpc0, 32'(36 - 4 * (i % 4)));
            chk("t3_pc", 1, hpc1, 32'(36 - 4 * i));
        end
        repeat (4) cyc(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t3_timeout", 0, 32'(timeout0), 32'd1);

        // Halt retiring on the watchdog's last cycle
        cyc(1'b1, 1'b0, 32'h0, 32'h0);
        repeat (9) cyc(1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 32'h40, HALT_WORD);
        settle(3'd0);
        chk("t4_halted", 1, 32'(halted1), 32'd1);
        chk("t4_timeout", 1, 32'(timeout1), 32'd0);
        chk("t4_cycle", 1, 32'(cyc1), 32'd10);
        chk("t4_pc", 1, hpc1, 32'h40);

        // Restart from HALTED, then a start during RUN is ignored
        cyc(1'b1, 1'b0, 32'h0, 32'h0);
        settle(3'd0);
        chk("t5_run", 0, 32'(run0), 32'd1);
        chk("t5_cycle", 0, 32'(cyc0), 32'd0);
        chk("t5_instr", 1, 32'(ins1), 32'd0);
        chk("t5_valid", 1, 32'(hv1), 32'd0);
        repeat (2) cyc(1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b1, 32'h80, LW_WORD);
        cyc(1'b1, 1'b0, 32'h0, 32'h0);
        settle(3'd0);
        chk("t5_run_cycle", 0, 32'(cyc0), 32'd5);
        chk("t5_run_instr", 1, 32'(ins1), 32'd1);
        chk("t5_run_pc", 1, hpc1, 32'h80);

        // Asynchronous reset between edges, then start with PCWre in IDLE
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_run", 0, 32'(run0), 32'd0);
        chk("t6_cycle", 0, 32'(cyc0), 32'd0);
        chk("t6_instr", 1, 32'(ins1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b1, 32'h200, LW_WORD);
        settle(3'd0);
        chk("t6_start_run", 0, 32'(run0), 32'd1);
        chk("t6_start_instr", 0, 32'(ins0), 32'd0);
        chk("t6_start_valid", 1, 32'(hv1), 32'd0);
        repeat (3) cyc(1'b0, 1'b0, 32'h0, 32'h0);

        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
